ahb_ram_ctrl: RTL and testbench
===============================

Name: ahb_ram_ctrl

Overview:
AHB-Lite slave controller that sequences the single-port 256K x 32 RAM macro (async read, sync word write, 18-bit word address). Converts AHB address/data-phase transfers into RAM read and write cycles. Byte and halfword writes are done as a same-cycle read-modify-write, since the RAM has a single word-wide write enable. Adds programmable wait states and a two-cycle ERROR response for illegal transfers. Sits between the AHB interconnect and the RAM instance inside the AHB slave RAM subsystem.

Parameters:
WAIT_STATES, 0, number of hreadyout-low cycles inserted at the start of every data phase (0..15)
PROT_WORDS, 1024, number of write-protected words starting at word address 0 (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active high
hsel  in  1  slave select
haddr  in  32  byte address; only [19:0] used
htrans  in  2  transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hwrite  in  1  1 = write
hsize  in  3  0 = byte, 1 = half, 2 = word; values above 2 are illegal
hwdata  in  32  write data, valid throughout the data phase
hready_in  in  1  bus-level HREADY
hrdata  out  32  read data
hreadyout  out  1  slave ready
hresp  out  1  0 = OKAY, 1 = ERROR
ram_a  out  18  RAM word address
ram_d  out  32  RAM write data
ram_we  out  1  RAM write enable
ram_q  in  32  RAM read data; combinational function of ram_a

Behaviour:
- Reset (async, any state): state = IDLE, hreadyout = 1, hresp = 0, hrdata = 0, ram_we = 0, ram_a = 0, latched address/size/write/lane registers = 0.
- Address phase is accepted when hsel & hready_in & htrans[1] all hold at a rising edge. On accept, latch haddr[19:0], hsize, hwrite.
  - IDLE or BUSY transfers, or hsel = 0, are not accepted; the slave stays or returns to IDLE with an OKAY zero-wait response.
- Legality is checked at accept:
  - hsize > 2 is an error.
  - hsize = 1 with haddr[0] = 1 is an error.
  - hsize = 2 with haddr[1:0] != 0 is an error.
  - An illegal transfer goes to ERR1; a legal one goes to WAIT if WAIT_STATES > 0, else ACCESS.
- States:
  - IDLE: hreadyout = 1, hresp = 0, no RAM access.
  - WAIT: hreadyout = 0, hresp = 0. A 4-bit counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0, go to ACCESS.
  - ACCESS: hreadyout = 1, hresp = 0. This is the final data-phase cycle. At its edge, go to a new address phase if one is accepted, else IDLE.
  - ERR1: hreadyout = 0, hresp = 1. Next state is ERR2 unconditionally.
  - ERR2: hreadyout = 1, hresp = 1. New address phase accepted per the normal rule, else IDLE.
- ram_a = latched haddr[19:2] in every state; it holds its last value in IDLE.
- Reads:
  - hrdata = ram_q in ACCESS of a read, and 0 in all other cycles.
  - The full word is returned regardless of hsize; the master selects lanes.
  - Latency is WAIT_STATES+1 cycles from the address-phase edge.
- Writes:
  - ram_we = 1 only in ACCESS of a legal write; it is combinational from state.
  - ram_d = ram_q with the selected little-endian byte lanes replaced by the matching hwdata lanes.
  - Byte lanes: byte uses lane haddr[1:0]; half uses lanes {haddr[1],0} and +1; word uses all four lanes.
  - The RAM latches the word at the ACCESS rising edge.
- No write ever occurs in WAIT, ERR1, ERR2 or IDLE.
- Back-to-back transfers:
  - The next address is latched at the same edge that completes ACCESS or ERR2.
  - A read directly after a write to the same word returns the new data, because the RAM write completes at that edge.
- Master cancels during ERR2 (htrans = IDLE): the slave goes to IDLE.
- Reset asserted mid-WAIT or mid-ERR1: the transfer is abandoned with no RAM write; outputs take their reset values immediately.

Optional Feature:
AHB_RAM_CTRL_WPROT_EN
- Defined: a legal-size write with word address < PROT_WORDS is treated as illegal. It goes to ERR1 -> ERR2 with no RAM write. Reads of the protected region are unaffected.
- Undefined: no protection; PROT_WORDS is ignored.

Test Plan:
- Word write 0xDEADBEEF to haddr 0x00010, then word read of the same address, WAIT_STATES = 0 -> ram_we high for exactly 1 cycle with ram_a = 0x00004; read returns 0xDEADBEEF one cycle after the address phase; hresp = 0 throughout.
- Word 0x11223344 at 0x20, then byte write hwdata = 0x00AA0000 at 0x22, then read -> 0x11AA3344. Halfword write hwdata = 0x5566xxxx at 0x22, then read -> 0x55663344.
- WAIT_STATES = 3, read -> hreadyout low for 3 cycles, hrdata valid on the 4th; hrdata = 0 during the wait cycles.
- Halfword write at 0x31 and hsize = 3 read at 0x40 -> ERR1/ERR2 sequence (hresp = 1 for 2 cycles, hreadyout 0 then 1); ram_we never asserted; RAM contents unchanged.
- Back-to-back NONSEQ write 0xA5A5A5A5 to 0x80 followed by read of 0x80 -> read data 0xA5A5A5A5 with no stall.
- rst pulsed during the second WAIT cycle of a write -> hreadyout = 1, ram_we = 0 immediately; the target word keeps its old value.
- With AHB_RAM_CTRL_WPROT_EN and PROT_WORDS = 1024: write to 0x00FFC -> ERROR, no write; write to 0x01000 -> OKAY, written.

Source files
------------

// File: rtl/ahb_ram_ctrl.sv
// ============================================================================
// ahb_ram_ctrl
//
// AHB-Lite slave that sequences a single-port 256K x 32 RAM macro
// (asynchronous read, synchronous word write, 18-bit word address).
// Byte and halfword writes are merged into the current RAM word in the same
// cycle (read-modify-write), because the macro has one word-wide write enable.
// Programmable wait states are inserted at the start of every data phase.
// Illegal transfers get the two-cycle AHB ERROR response.
//
// Parameters:
//   WAIT_STATES  hreadyout-low cycles at the start of each data phase (0..15)
//   PROT_WORDS   write-protected words from word address 0 (protection build)
//
// Optional feature macro:
//   AHB_RAM_CTRL_WPROT_EN  when defined, a write whose word address is below
//                          PROT_WORDS is answered with ERROR and not performed
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active high
//   hsel       in   slave select
//   haddr      in   byte address, bits [19:0] used
//   htrans     in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite     in   1 = write
//   hsize      in   0 = byte, 1 = half, 2 = word
//   hwdata     in   write data, valid during the data phase
//   hready_in  in   bus-level HREADY
//   hrdata     out  read data (zero outside the final cycle of a read)
//   hreadyout  out  slave ready
//   hresp      out  0 = OKAY, 1 = ERROR
//   ram_a      out  RAM word address
//   ram_d      out  RAM write data
//   ram_we     out  RAM write enable
//   ram_q      in   RAM read data, combinational from ram_a
// ============================================================================
module ahb_ram_ctrl #(
    parameter int WAIT_STATES = 0,
    parameter int PROT_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [17:0] ram_a,
    output logic [31:0] ram_d,
    output logic        ram_we,
    input  logic [31:0] ram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state;
    state_t      state_next;

    logic        phase_open;
    logic        accept;
    logic        size_ok;
    logic        prot_hit;
    logic        legal;
    logic [3:0]  lanes_in;

    logic [19:0] addr_q;
    logic [2:0]  size_q;
    logic        write_q;
    logic [3:0]  lanes_q;
    logic [3:0]  wait_cnt;

    // A new address phase can only be taken in a cycle where this slave is
    // driving hreadyout high, i.e. the last cycle of a data phase or idle.
    assign phase_open = (state == S_IDLE) || (state == S_ACCESS) || (state == S_ERR2);
    assign accept     = phase_open & hsel & hready_in & htrans[1];

    always_comb begin
        size_ok = 1'b0;
        case (hsize)
            3'd0:    size_ok = 1'b1;
            3'd1:    size_ok = ~haddr[0];
            3'd2:    size_ok = (haddr[1:0] == 2'b00);
            default: size_ok = 1'b0;
        endcase
    end

`ifdef AHB_RAM_CTRL_WPROT_EN
    assign prot_hit = hwrite && ({14'd0, haddr[19:2]} < 32'(PROT_WORDS));
`else
    // PROT_WORDS only matters in the protection build; tie it off here.
    logic prot_unused;
    assign prot_unused = (PROT_WORDS > 0);
    assign prot_hit    = 1'b0;
`endif

    assign legal = size_ok & ~prot_hit;

    // Little-endian byte-lane mask of the bytes the transfer touches.
    always_comb begin
        lanes_in = 4'b1111;
        case (hsize)
            3'd0:    lanes_in = 4'b0001 << haddr[1:0];
            3'd1:    lanes_in = haddr[1] ? 4'b1100 : 4'b0011;
            default: lanes_in = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ACCESS, S_ERR2: begin
                if (accept) begin
                    if (!legal) begin
                        state_next = S_ERR1;
                    end else if (HAS_WAIT) begin
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_ACCESS;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_ACCESS;
                end
            end
            S_ERR1:  state_next = S_ERR2;
            default: state_next = S_IDLE;
        endcase
    end

    // hrdata, ram_we and the handshake outputs depend only on the state and
    // the latched transfer, so the master sees them without any extra delay.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        ram_we    = 1'b0;
        hrdata    = 32'h0;
        case (state)
            S_WAIT: begin
                hreadyout = 1'b0;
            end
            S_ACCESS: begin
                ram_we = write_q;
                if (!write_q) begin
                    hrdata = ram_q;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: begin
                hresp = 1'b1;
            end
            default: begin
                hreadyout = 1'b1;
            end
        endcase
    end

    // Address-phase capture. The counter is loaded one below the wait count
    // so that WAIT is left when it reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 20'h0;
            size_q   <= 3'h0;
            write_q  <= 1'b0;
            lanes_q  <= 4'h0;
            wait_cnt <= 4'h0;
        end else begin
            if (accept) begin
                addr_q   <= haddr[19:0];
                size_q   <= hsize;
                write_q  <= hwrite;
                lanes_q  <= lanes_in;
                wait_cnt <= WAIT_LOAD;
            end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    assign ram_a = addr_q[19:2];

    // Read-modify-write: untouched lanes come straight back from the RAM.
    always_comb begin
        ram_d = ram_q;
        for (int i = 0; i < 4; i++) begin
            if (lanes_q[i]) begin
                ram_d[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, haddr[31:20], htrans[0], addr_q[1:0], size_q};

endmodule

// File: tb/tb_ahb_ram_ctrl.sv
`timescale 1ns/1ps
module tb_ahb_ram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        tgt;

    logic        hsel0, hsel3;
    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3;
    logic        hresp0, hresp3;
    logic [17:0] ram_a0, ram_a3;
    logic [31:0] ram_d0, ram_d3;
    logic        ram_we0, ram_we3;
    logic [31:0] ram_q0, ram_q3;

    assign hsel0 = hsel & ~tgt;
    assign hsel3 = hsel & tgt;

    ahb_ram_ctrl #(.WAIT_STATES(0), .PROT_WORDS(1024)) dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hreadyout0),
        .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0),
        .ram_a(ram_a0), .ram_d(ram_d0), .ram_we(ram_we0), .ram_q(ram_q0)
    );

    ahb_ram_ctrl #(.WAIT_STATES(3), .PROT_WORDS(1024)) dut3 (
        .clk(clk), .rst(rst), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hreadyout3),
        .hrdata(hrdata3), .hreadyout(hreadyout3), .hresp(hresp3),
        .ram_a(ram_a3), .ram_d(ram_d3), .ram_we(ram_we3), .ram_q(ram_q3)
    );

    // RAM macro behaviour: asynchronous read, word write at the rising edge.
    logic [31:0] mem0 [0:262143];
    logic [31:0] mem3 [0:262143];
    assign ram_q0 = mem0[ram_a0];
    assign ram_q3 = mem3[ram_a3];
    always @(posedge clk) if (ram_we0) mem0[ram_a0] <= ram_d0;
    always @(posedge clk) if (ram_we3) mem3[ram_a3] <= ram_d3;

    // View of whichever instance is currently addressed.
    logic [31:0] s_hrdata;
    logic        s_hreadyout, s_hresp, s_ram_we;
    logic [17:0] s_ram_a;
    assign s_hrdata    = tgt ? hrdata3    : hrdata0;
    assign s_hreadyout = tgt ? hreadyout3 : hreadyout0;
    assign s_hresp     = tgt ? hresp3     : hresp0;
    assign s_ram_we    = tgt ? ram_we3    : ram_we0;
    assign s_ram_a     = tgt ? ram_a3     : ram_a0;

`ifdef AHB_RAM_CTRL_WPROT_EN
    // Keep general traffic above the protected region in this build.
    localparam logic [31:0] BASE = 32'h0001_0000;
`else
    localparam logic [31:0] BASE = 32'h0000_0000;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model0 [int];
    logic [31:0] model3 [int];
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic logic [31:0] model_rd(input logic t, input int w);
        if (t) return model3.exists(w) ? model3[w] : 32'h0;
        return model0.exists(w) ? model0[w] : 32'h0;
    endfunction

    function automatic void model_wr(input logic t, input int w, input logic [31:0] v);
        if (t) model3[w] = v;
        else   model0[w] = v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] a, input logic [2:0] sz);
        logic [31:0] r;
        r = old;
        case (sz)
            3'd0:    r[8*a +: 8] = wd[8*a +: 8];
            3'd1:    r[16*a[1] +: 16] = wd[16*a[1] +: 16];
            default: r = wd;
        endcase
        return r;
    endfunction

    // One non-pipelined transfer. Starts and ends right after a falling edge;
    // a following call therefore issues its address in the final data cycle.
    task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                            input logic [31:0] wdata, input logic err, input string tag);
        exp_t        e;
        int          w;
        int          ws;
        int          waits;
        int          we_cnt;
        logic [17:0] last_a;
        logic        done;
        w  = int'(addr[19:2]);
        ws = tgt ? 3 : 0;
        if (err) begin
            e = '{32'h0, 1'b1, 1};
        end else if (wr) begin
            model_wr(tgt, w, merge(model_rd(tgt, w), wdata, addr[1:0], sz));
            e = '{32'h0, 1'b0, ws};
        end else begin
            e = '{model_rd(tgt, w), 1'b0, ws};
        end
        exp_q.push_back(e);

        hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = sz;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
        waits = 0; we_cnt = 0; last_a = '0; done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (s_ram_we) begin
                we_cnt++;
                last_a = s_ram_a;
            end
            if (s_hreadyout) begin
                done = 1'b1;
                break;
            end
            waits++;
            n_cmp++;
            if (s_hrdata !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL %s stall_hrdata: got %h want 00000000", tag, s_hrdata);
            end
            n_cmp++;
            if (s_hresp !== exp_q[0].resp) begin
                n_fail++;
                $display("[TB] FAIL %s stall_hresp: got %b want %b", tag, s_hresp, exp_q[0].resp);
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL %s timeout: got hreadyout %b want 1 within 40 cycles", tag, s_hreadyout);
        end else begin
            n_cmp++;
            if (s_hrdata !== e.rdata) begin
                n_fail++;
                $display("[TB] FAIL %s hrdata: got %h want %h", tag, s_hrdata, e.rdata);
            end
            n_cmp++;
            if (s_hresp !== e.resp) begin
                n_fail++;
                $display("[TB] FAIL %s hresp: got %b want %b", tag, s_hresp, e.resp);
            end
            n_cmp++;
            if (waits != e.waits) begin
                n_fail++;
                $display("[TB] FAIL %s waits: got %0d want %0d", tag, waits, e.waits);
            end
        end
        n_cmp++;
        if (wr && !err) begin
            if (we_cnt != 1 || last_a !== addr[19:2]) begin
                n_fail++;
                $display("[TB] FAIL %s ram_we: got %0d pulses at %h want 1 at %h",
                         tag, we_cnt, last_a, addr[19:2]);
            end
        end else if (we_cnt != 0) begin
            n_fail++;
            $display("[TB] FAIL %s ram_we: got %0d pulses want 0", tag, we_cnt);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({hreadyout0, hresp0, ram_we0, hrdata0, ram_a0} !== {3'b100, 32'h0, 18'h0}) begin
            n_fail++;
            $display("[TB] FAIL reset_dut0: got rdy=%b resp=%b we=%b rd=%h a=%h want 1 0 0 0 0",
                     hreadyout0, hresp0, ram_we0, hrdata0, ram_a0);
        end
        n_cmp++;
        if ({hreadyout3, hresp3, ram_we3, hrdata3, ram_a3} !== {3'b100, 32'h0, 18'h0}) begin
            n_fail++;
            $display("[TB] FAIL reset_dut3: got rdy=%b resp=%b we=%b rd=%h a=%h want 1 0 0 0 0",
                     hreadyout3, hresp3, ram_we3, hrdata3, ram_a3);
        end
    endtask

    task automatic test_word_rw;
        ahb_xfer(BASE + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, "word_wr");
        ahb_xfer(BASE + 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, "word_rd");
    endtask

    task automatic test_byte_half;
        ahb_xfer(BASE + 32'h20, 1'b1, 3'd2, 32'h11223344, 1'b0, "bh_word");
        ahb_xfer(BASE + 32'h22, 1'b1, 3'd0, 32'h00AA0000, 1'b0, "bh_byte2");
        ahb_xfer(BASE + 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, "bh_rd1");
        ahb_xfer(BASE + 32'h22, 1'b1, 3'd1, 32'h5566BEEF, 1'b0, "bh_half_hi");
        ahb_xfer(BASE + 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, "bh_rd2");
        ahb_xfer(BASE + 32'h23, 1'b1, 3'd0, 32'h77000000, 1'b0, "bh_byte3");
        ahb_xfer(BASE + 32'h20, 1'b1, 3'd0, 32'h000000EE, 1'b0, "bh_byte0");
        ahb_xfer(BASE + 32'h20, 1'b1, 3'd1, 32'hFFFF0102, 1'b0, "bh_half_lo");
        ahb_xfer(BASE + 32'h21, 1'b0, 3'd0, 32'h0, 1'b0, "bh_rd_byte");
    endtask

    task automatic test_error;
        ahb_xfer(BASE + 32'h30, 1'b1, 3'd2, 32'h0BADF00D, 1'b0, "err_pre30");
        ahb_xfer(BASE + 32'h40, 1'b1, 3'd2, 32'h600DCAFE, 1'b0, "err_pre40");
        ahb_xfer(BASE + 32'h31, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, "err_half_odd");
        ahb_xfer(BASE + 32'h40, 1'b0, 3'd3, 32'h0, 1'b1, "err_size3");
        // Master has already dropped to IDLE during ERR2: slave must settle.
        @(negedge clk);
        n_cmp++;
        if ({s_hreadyout, s_hresp} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL err_cancel: got rdy=%b resp=%b want 1 0", s_hreadyout, s_hresp);
        end
        ahb_xfer(BASE + 32'h32, 1'b1, 3'd2, 32'h12121212, 1'b1, "err_word_mis");
        ahb_xfer(BASE + 32'h30, 1'b0, 3'd2, 32'h0, 1'b0, "err_rd30");
        ahb_xfer(BASE + 32'h40, 1'b0, 3'd2, 32'h0, 1'b0, "err_rd40");
    endtask

    task automatic test_back_to_back;
        exp_t e;
        model_wr(tgt, int'(BASE[19:2]) + 32, 32'hA5A5A5A5);
        exp_q.push_back('{32'h0, 1'b0, 0});
        hsel = 1'b1; haddr = BASE + 32'h80; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({s_hreadyout, s_hresp, s_ram_we, s_ram_a} !== {3'b101, BASE[19:2] + 18'h20}) begin
            n_fail++;
            $display("[TB] FAIL b2b_write: got rdy=%b resp=%b we=%b a=%h want 1 %b 1 %h",
                     s_hreadyout, s_hresp, s_ram_we, s_ram_a, e.resp, BASE[19:2] + 18'h20);
        end
        exp_q.push_back('{model_rd(tgt, int'(BASE[19:2]) + 32), 1'b0, 0});
        hwdata = 32'hA5A5A5A5; haddr = BASE + 32'h80; hwrite = 1'b0; htrans = 2'b10;
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({s_hreadyout, s_ram_we} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL b2b_read_stall: got rdy=%b we=%b want 1 0", s_hreadyout, s_ram_we);
        end
        n_cmp++;
        if (s_hrdata !== e.rdata) begin
            n_fail++;
            $display("[TB] FAIL b2b_read_data: got %h want %h", s_hrdata, e.rdata);
        end
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (s_hrdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle_hrdata: got %h want 00000000", s_hrdata);
        end
    endtask

    task automatic test_wprot;
`ifdef AHB_RAM_CTRL_WPROT_EN
        ahb_xfer(32'h00FFC, 1'b1, 3'd2, 32'h13579BDF, 1'b1, "wprot_low");
`else
        ahb_xfer(32'h00FFC, 1'b1, 3'd2, 32'h13579BDF, 1'b0, "wprot_low");
        ahb_xfer(32'h00FFC, 1'b0, 3'd2, 32'h0, 1'b0, "wprot_low_rd");
`endif
        ahb_xfer(32'h01000, 1'b1, 3'd2, 32'h2468ACE0, 1'b0, "wprot_edge");
        ahb_xfer(32'h01000, 1'b0, 3'd2, 32'h0, 1'b0, "wprot_edge_rd");
    endtask

    task automatic test_wait_states;
        ahb_xfer(BASE + 32'h200, 1'b1, 3'd2, 32'h89ABCDEF, 1'b0, "ws_wr");
        ahb_xfer(BASE + 32'h200, 1'b0, 3'd2, 32'h0, 1'b0, "ws_rd");
        ahb_xfer(BASE + 32'h201, 1'b1, 3'd0, 32'h00005A00, 1'b0, "ws_byte1");
        ahb_xfer(BASE + 32'h203, 1'b0, 3'd0, 32'h0, 1'b0, "ws_rd_byte");
        ahb_xfer(BASE + 32'h206, 1'b0, 3'd2, 32'h0, 1'b1, "ws_err");
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] a;
        a = BASE + 32'h100;
        ahb_xfer(a, 1'b1, 3'd2, 32'hCAFEF00D, 1'b0, "rmw_pre");
        hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        @(negedge clk);
        n_cmp++;
        if (s_hreadyout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rmw_in_wait: got hreadyout %b want 0", s_hreadyout);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({s_hreadyout, s_hresp, s_ram_we, s_ram_a} !== {3'b100, 18'h0}) begin
            n_fail++;
            $display("[TB] FAIL rmw_async: got rdy=%b resp=%b we=%b a=%h want 1 0 0 0",
                     s_hreadyout, s_hresp, s_ram_we, s_ram_a);
        end
        @(negedge clk);
        rst = 1'b0;
        ahb_xfer(a, 1'b0, 3'd2, 32'h0, 1'b0, "rmw_read");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish want finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hwdata = '0; tgt = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        tgt = 1'b0;
        test_word_rw();
        test_byte_half();
        test_error();
        test_back_to_back();
        test_wprot();
        tgt = 1'b1;
        test_wait_states();
        test_reset_mid_wait();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
